// File: rtl/mmu_paged.sv
// Paged MMU for a 6809 bus: task/page map translation, write protect and fault capture.
// Optional fault capture is built when MMU_PAGED_FAULT_CAPTURE_EN is defined.
module mmu_paged #(
  parameter int unsigned TASK_BITS   = 5,
  parameter int unsigned PAGE_BITS   = 3,
  parameter int unsigned PHYS_BITS   = 7,
  parameter int unsigned MASK_CYCLES = 3,
  parameter logic [15:0] IO_ADDR_MIN = 16'hFC00,
  parameter logic [15:0] IO_ADDR_MAX = 16'hFEFF,
  parameter logic [15:0] MMU_BASE    = 16'hFE20
) (
  input  logic                   i_clkx4,
  input  logic                   i_reset,
  input  logic                   i_e,
  input  logic [15:0]            i_addr,
  input  logic                   i_ba,
  input  logic                   i_bs,
  input  logic                   i_rnw,
  input  logic [7:0]             i_data_in,
  output logic [7:0]             o_data_out,
  output logic                   o_data_oe,
  output logic [PHYS_BITS-1:0]   o_pa_hi,
  output logic [15-PAGE_BITS:0]  o_pa_lo,
  output logic                   o_wr_en,
  output logic                   o_intmask,
  output logic                   o_irq
);

  localparam int unsigned IdxW     = TASK_BITS + PAGE_BITS;
  localparam int unsigned MapDepth = 2 ** IdxW;
  localparam int unsigned EntW     = PHYS_BITS + 1;
  localparam int unsigned MaskW    = (MASK_CYCLES < 1) ? 1 : $clog2(MASK_CYCLES + 1);

  logic                 r_e_q;
  logic                 r_enmmu;
  logic                 r_protect;
  logic                 r_u;
  logic [TASK_BITS-1:0] r_access_key;
  logic [TASK_BITS-1:0] r_task_key;
  logic [MaskW-1:0]     r_mask_cnt;

  // Entry layout: {WP, page}; the pad bits of the byte format are not stored.
  logic [EntW-1:0]      r_map [MapDepth];

  logic                 w_cyc_end;
  logic                 w_access_vector;
  logic                 w_hw_en;
  logic                 w_mmu_access;
  logic                 w_io;
  logic [PAGE_BITS-1:0] w_lpage;
  logic [TASK_BITS-1:0] w_cur_task;
  logic [IdxW-1:0]      w_xlat_idx;
  logic [IdxW-1:0]      w_win_idx;
  logic [EntW-1:0]      w_xlat_ent;
  logic [EntW-1:0]      w_win_ent;
  logic [PHYS_BITS-1:0] w_identity;
  logic                 w_viol;
  logic                 w_reg_wr;
  logic                 w_map_wr;
  logic                 w_rti;
  logic                 w_fault;

  assign w_cyc_end       = r_e_q & ~i_e;
  assign w_access_vector = ~i_ba & i_bs & i_rnw;
  assign w_hw_en         = ~r_enmmu | ~r_u | ~r_protect;
  assign w_mmu_access    = w_hw_en & (i_addr[15:5] == MMU_BASE[15:5]);
  assign w_io            = (i_addr >= IO_ADDR_MIN) && (i_addr <= IO_ADDR_MAX);

  assign w_lpage    = i_addr[15 -: PAGE_BITS];
  assign w_cur_task = (r_u & ~w_access_vector) ? r_task_key : '0;
  assign w_xlat_idx = {w_cur_task, w_lpage};
  assign w_win_idx  = {r_access_key, i_addr[PAGE_BITS-1:0]};
  assign w_xlat_ent = r_map[w_xlat_idx];
  assign w_win_ent  = r_map[w_win_idx];
  assign w_identity = PHYS_BITS'(w_lpage);

  assign w_viol   = r_enmmu & r_u & ~w_io & ~i_rnw & w_xlat_ent[PHYS_BITS];
  assign w_reg_wr = w_cyc_end & w_mmu_access & ~i_rnw & ~i_addr[4];
  assign w_map_wr = w_cyc_end & w_mmu_access & ~i_rnw & i_addr[4];
  assign w_rti    = w_cyc_end & w_mmu_access & i_rnw & ~i_addr[4] & (i_addr[2:0] == 3'd3);

  assign o_pa_hi   = (r_enmmu & ~w_io) ? w_xlat_ent[PHYS_BITS-1:0] : w_identity;
  assign o_pa_lo   = i_addr[15-PAGE_BITS:0];
  assign o_wr_en   = ~w_viol;
  assign o_intmask = w_access_vector | (r_mask_cnt != '0);
  assign o_data_oe = i_e & i_rnw & w_mmu_access;
  assign o_irq     = w_fault;

`ifdef MMU_PAGED_FAULT_CAPTURE_EN
  logic                 r_fault;
  logic [15:0]          r_fault_addr;
  logic [TASK_BITS-1:0] r_fault_task;
  logic                 w_fault_clr;
  logic                 w_fault_set;

  assign w_fault_clr = w_reg_wr & (i_addr[2:0] == 3'd0) & i_data_in[3];
  // A held fault keeps its capture unless it is being cleared in this very cycle.
  assign w_fault_set = w_cyc_end & w_viol & (~r_fault | w_fault_clr);
  assign w_fault     = r_fault;

  always_ff @(posedge i_clkx4) begin
    if (i_reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fault_task <= '0;
    end else if (w_fault_set) begin
      r_fault      <= 1'b1;
      r_fault_addr <= i_addr;
      r_fault_task <= r_task_key;
    end else if (w_fault_clr) begin
      r_fault      <= 1'b0;
    end
  end
`else
  assign w_fault = 1'b0;
`endif

  always_comb begin
    o_data_out = '0;
    if (w_mmu_access) begin
      if (i_addr[4]) begin
        o_data_out[7]             = w_win_ent[PHYS_BITS];
        o_data_out[PHYS_BITS-1:0] = w_win_ent[PHYS_BITS-1:0];
      end else begin
        case (i_addr[2:0])
          3'd0: o_data_out = {4'b0, w_fault, r_u, r_protect, r_enmmu};
          3'd1: o_data_out[TASK_BITS-1:0] = r_access_key;
          3'd2: o_data_out[TASK_BITS-1:0] = r_task_key;
          3'd3: o_data_out = 8'h3B;
`ifdef MMU_PAGED_FAULT_CAPTURE_EN
          3'd4: o_data_out = r_fault_addr[15:8];
          3'd5: o_data_out = r_fault_addr[7:0];
          3'd6: o_data_out[TASK_BITS-1:0] = r_fault_task;
`endif
          default: o_data_out = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clkx4) begin
    if (i_reset) begin
      r_e_q        <= 1'b0;
      r_enmmu      <= 1'b0;
      r_protect    <= 1'b0;
      r_u          <= 1'b0;
      r_access_key <= '0;
      r_task_key   <= '0;
      r_mask_cnt   <= '0;
    end else begin
      r_e_q <= i_e;
      if (w_reg_wr) begin
        case (i_addr[2:0])
          3'd0: begin
            r_protect <= i_data_in[1];
            r_enmmu   <= i_data_in[0];
          end
          3'd1:    r_access_key <= i_data_in[TASK_BITS-1:0];
          3'd2:    r_task_key   <= i_data_in[TASK_BITS-1:0];
          default: ;
        endcase
      end
      if (w_cyc_end) begin
        // Vector fetch outranks the RTI hook and restarts the mask window.
        if (w_access_vector) begin
          r_u        <= 1'b0;
          r_mask_cnt <= MaskW'(MASK_CYCLES);
        end else begin
          if (w_rti) r_u <= 1'b1;
          if (r_mask_cnt != '0) r_mask_cnt <= r_mask_cnt - MaskW'(1);
        end
      end
    end
  end

  // Map RAM has no reset; a reset cycle still blocks the write.
  always_ff @(posedge i_clkx4) begin
    if (!i_reset && w_map_wr) begin
      r_map[w_win_idx] <= {i_data_in[7], i_data_in[PHYS_BITS-1:0]};
    end
  end

endmodule

// File: tb/tb_mmu_paged.sv
// Bench for mmu_paged: bus-cycle model of the MMU checked every clock, plus directed literals.
module tb_mmu_paged;

`ifdef MMU_PAGED_FAULT_CAPTURE_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  logic        clkx4, reset, e, ba, bs, rnw;
  logic [15:0] addr;
  logic [7:0]  data_in, data_out;
  logic        data_oe, wr_en, intmask, irq;
  logic [6:0]  pa_hi;
  logic [12:0] pa_lo;

  mmu_paged dut (
    .i_clkx4   (clkx4),
    .i_reset   (reset),
    .i_e       (e),
    .i_addr    (addr),
    .i_ba      (ba),
    .i_bs      (bs),
    .i_rnw     (rnw),
    .i_data_in (data_in),
    .o_data_out(data_out),
    .o_data_oe (data_oe),
    .o_pa_hi   (pa_hi),
    .o_pa_lo   (pa_lo),
    .o_wr_en   (wr_en),
    .o_intmask (intmask),
    .o_irq     (irq)
  );

  initial clkx4 = 1'b0;
  always #5 clkx4 = ~clkx4;

  typedef struct packed {
    logic [15:0] addr;
    logic        rnw;
    logic        ba;
    logic        bs;
    logic [7:0]  data;
  } txn_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        mmu;
    logic        oe;
    logic [6:0]  pa_hi;
    logic [12:0] pa_lo;
    logic        wr_en;
    logic        intmask;
    logic        irq;
  } exp_t;

  // Model state, in the terms of the register map.
  bit       m_enmmu, m_protect, m_u, m_fault;
  int       m_akey, m_tkey, m_mask, m_fa, m_ft;
  bit [7:0] m_map [32][8];

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   pend = 1'b0;
  txn_t pend_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_enmmu = 0; m_protect = 0; m_u = 0; m_fault = 0;
    m_akey = 0; m_tkey = 0; m_mask = 0; m_fa = 0; m_ft = 0;
  endfunction

  function automatic bit is_io(input int a);
    return a >= 'hFC00 && a <= 'hFEFF;
  endfunction

  function automatic bit in_mmu(input int a);
    return (!m_enmmu || !m_u || !m_protect) && a >= 'hFE20 && a < 'hFE40;
  endfunction

  function automatic bit [7:0] xlat_entry(input int a, input bit av);
    int t = (m_u && !av) ? m_tkey : 0;
    return m_map[t][a / 8192];
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    int   a   = int'(addr);
    bit   av  = !ba && bs && rnw;
    bit   io  = is_io(a);
    bit [7:0] ent = xlat_entry(a, av);
    int   off = a - 'hFE20;
    x.mmu     = in_mmu(a);
    x.oe      = e && rnw && x.mmu;
    x.pa_hi   = (m_enmmu && !io) ? ent[6:0] : 7'(a / 8192);
    x.pa_lo   = 13'(a % 8192);
    x.wr_en   = !(m_enmmu && m_u && !io && !rnw && ent[7]);
    x.intmask = av || (m_mask > 0);
    x.irq     = m_fault;
    x.data    = 8'h00;
    if (off >= 16) x.data = m_map[m_akey][off % 8];
    else begin
      case (off % 8)
        0: x.data = {4'b0, m_fault, m_u, m_protect, m_enmmu};
        1: x.data = 8'(m_akey);
        2: x.data = 8'(m_tkey);
        3: x.data = 8'h3B;
        4: x.data = 8'(m_fa / 256);
        5: x.data = 8'(m_fa % 256);
        6: x.data = 8'(m_ft);
        default: x.data = 8'h00;
      endcase
    end
    return x;
  endfunction

  // Applies one completed bus cycle to the model (the E falling edge).
  function automatic void commit(input txn_t t);
    int a    = int'(t.addr);
    bit av   = !t.ba && t.bs && t.rnw;
    bit mmu  = in_mmu(a);
    int off  = a - 'hFE20;
    bit [7:0] ent = xlat_entry(a, av);
    bit viol = m_enmmu && m_u && !is_io(a) && !t.rnw && ent[7];
    bit clr  = 0;
    bit rti  = mmu && t.rnw && off < 16 && (off % 8) == 3;
    int tk   = m_tkey;
    if (mmu && !t.rnw) begin
      if (off >= 16) m_map[m_akey][off % 8] = t.data;
      else begin
        case (off % 8)
          0: begin clr = t.data[3]; m_protect = t.data[1]; m_enmmu = t.data[0]; end
          1: m_akey = int'(t.data) % 32;
          2: m_tkey = int'(t.data) % 32;
          default: ;
        endcase
      end
    end
    if (FaultEn && viol && (!m_fault || clr)) begin
      m_fault = 1; m_fa = a; m_ft = tk;
    end else if (FaultEn && clr) m_fault = 0;
    if (av) begin
      m_u = 0; m_mask = 3;
    end else begin
      if (rti) m_u = 1;
      if (m_mask > 0) m_mask--;
    end
  endfunction

  always @(negedge clkx4) begin
    exp_t x;
    if (chk_en) begin
      x = model_out();
      check("pa_hi", 16'(pa_hi), 16'(x.pa_hi));
      check("pa_lo", 16'(pa_lo), 16'(x.pa_lo));
      check("wr_en", 16'(wr_en), 16'(x.wr_en));
      check("intmask", 16'(intmask), 16'(x.intmask));
      check("irq", 16'(irq), 16'(x.irq));
      check("data_oe", 16'(data_oe), 16'(x.oe));
      if (x.mmu) check("data_out", 16'(data_out), 16'(x.data));
    end
  end

  // One bus cycle: E low (previous cycle commits), drive, E high two clocks.
  task automatic bus(input logic [15:0] a, input bit r, input logic [7:0] d, input bit vec = 0);
    e = 1'b0;
    @(posedge clkx4); #1;
    if (pend) commit(pend_t);
    pend = 1'b0;
    addr = a; rnw = r; data_in = d; ba = 1'b0; bs = vec;
    @(posedge clkx4); #1;
    e = 1'b1;
    @(posedge clkx4); #1;
    @(posedge clkx4); #1;
    pend_t = '{addr: a, rnw: r, ba: 1'b0, bs: vec, data: d};
    pend = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; e = 1'b0;
    @(posedge clkx4); #1;
    model_reset(); pend = 1'b0;
    @(posedge clkx4); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; e = 1'b0; addr = 16'h0000; rnw = 1'b1; ba = 1'b0; bs = 1'b0; data_in = 8'h00;
    do_reset();
    chk_en = 1'b1;

    // Fill the whole map: page (t*8+p+16)&7F, WP on logical page 6.
    for (int t = 0; t < 32; t++) begin
      bus(16'hFE21, 1'b0, 8'(t));
      for (int p = 0; p < 8; p++)
        bus(16'hFE30 + 16'(p), 1'b0, 8'(((t * 8 + p + 16) & 'h7F) | ((p == 6) ? 'h80 : 0)));
    end

    do_reset();
    bus(16'hFE20, 1'b1, 8'h00);
    check("lit_reset_ctrl", 16'(data_out), 16'h00);
    check("lit_reset_oe", 16'(data_oe), 16'h1);
    bus(16'hA123, 1'b1, 8'h00);
    check("lit_identity_pa", 16'(pa_hi), 16'd5);
    check("lit_identity_wr", 16'(wr_en), 16'h1);
    check("lit_reset_intmask", 16'(intmask), 16'h0);

    bus(16'hFE21, 1'b0, 8'h02);
    bus(16'hFE33, 1'b0, 8'h85);
    bus(16'hFE3B, 1'b1, 8'h00);
    check("lit_map_alias", 16'(data_out), 16'h85);
    bus(16'hFE22, 1'b0, 8'h02);
    bus(16'hFE20, 1'b0, 8'h01);
    bus(16'hFE23, 1'b1, 8'h00);
    check("lit_rti_read", 16'(data_out), 16'h3B);
    bus(16'h6000, 1'b1, 8'h00);
    check("lit_xlat_task2", 16'(pa_hi), 16'd5);
    bus(16'hFE20, 1'b1, 8'h00);
    check("lit_ctrl_u", 16'(data_out), 16'h05);

    bus(16'h6010, 1'b0, 8'hAA);
    check("lit_wp_block", 16'(wr_en), 16'h0);
    bus(16'h6000, 1'b1, 8'h00);
    check("lit_irq_set", 16'(irq), 16'(FaultEn));
    bus(16'h7000, 1'b0, 8'h55);
    check("lit_wp_block2", 16'(wr_en), 16'h0);
    bus(16'hFE24, 1'b1, 8'h00);
    check("lit_fault_hi", 16'(data_out), FaultEn ? 16'h60 : 16'h00);
    bus(16'hFE25, 1'b1, 8'h00);
    check("lit_fault_lo_held", 16'(data_out), FaultEn ? 16'h10 : 16'h00);
    bus(16'hFE26, 1'b1, 8'h00);
    check("lit_fault_task", 16'(data_out), FaultEn ? 16'h02 : 16'h00);
    bus(16'hFE20, 0, 8'h09);
    bus(16'h6000, 1'b1, 8'h00);
    check("lit_irq_clear", 16'(irq), 16'h0);

    bus(16'hFFF8, 1'b1, 8'h00, 1'b1);
    check("lit_vec_pa", 16'(pa_hi), 16'd23);
    check("lit_vec_mask", 16'(intmask), 16'h1);
    for (int i = 0; i < 4; i++) begin
      bus(16'h0000, 1'b1, 8'h00);
      check("lit_mask_window", 16'(intmask), (i < 3) ? 16'h1 : 16'h0);
      check("lit_task0_pa", 16'(pa_hi), 16'd16);
    end
    bus(16'hFE20, 1'b1, 8'h00);
    check("lit_u_cleared", 16'(data_out), 16'h01);
    bus(16'h6000, 1'b1, 8'h00);
    check("lit_task0_pg3", 16'(pa_hi), 16'd19);

    bus(16'hFE23, 1'b1, 8'h00);
    bus(16'hFE20, 1'b0, 8'h03);
    bus(16'hFE20, 1'b1, 8'h00);
    check("lit_prot_oe", 16'(data_oe), 16'h0);
    check("lit_prot_io_pa", 16'(pa_hi), 16'd7);
    bus(16'hFE00, 1'b1, 8'h00);
    check("lit_io_identity", 16'(pa_hi), 16'd7);
    bus(16'h2000, 1'b1, 8'h00);
    check("lit_prot_xlat", 16'(pa_hi), 16'd33);
    bus(16'hFE20, 1'b0, 8'h00);
    check("lit_io_wr_ok", 16'(wr_en), 16'h1);
    bus(16'h6010, 1'b0, 8'h00);
    check("lit_prot_wp", 16'(wr_en), 16'h0);
    bus(16'hFFFE, 1'b1, 8'h00, 1'b1);
    bus(16'hFE20, 1'b0, 8'h08);

    // Reset lands while E is high in a CTRL write and is held across the E fall.
    bus(16'hFE20, 1'b0, 8'h03);
    reset = 1'b1;
    @(posedge clkx4); #1;
    model_reset(); pend = 1'b0;
    e = 1'b0;
    @(posedge clkx4); #1;
    reset = 1'b0;
    @(posedge clkx4); #1;
    bus(16'hFE20, 1'b1, 8'h00);
    check("lit_midreset_ctrl", 16'(data_out), 16'h00);
    bus(16'hA123, 1'b1, 8'h00);
    check("lit_midreset_pa", 16'(pa_hi), 16'd5);
    bus(16'h0000, 1'b1, 8'h00);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
